srv_mem_arb: RTL

//  Round-robin arbiter and sequencer in front of the single-port line-fill memory (srv_mem).

---
 rtl/srv_mem_pkg.sv | 28 ++
 rtl/srv_mem_arb_if.sv | 40 ++++
 rtl/srv_rr_arb.sv | 36 +++
 rtl/srv_mem_arb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/srv_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : srv_mem_pkg                                                   |
// | Purpose  : Shared widths, arbiter state encoding and line helpers for    |
// |            the line-fill memory front end.                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package srv_mem_pkg;

   localparam int LINE_W         = 128;
   localparam int ADDR_W         = 32;
   localparam int WORDS_PER_LINE = 4;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

   // Clear the word-in-line offset so the address points at the first word of its line
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(WORDS_PER_LINE - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/srv_mem_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: srv_mem_arb_if                                                |
// | Purpose  : Requester-side and memory-side signals of the line-fill       |
// |            arbiter. slave = arbiter view, master = environment view.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface srv_mem_arb_if
   import srv_mem_pkg::*;
#(
   parameter int N_REQ = 2
);

   // Requester side
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ*ADDR_W-1:0] addr_i;
   logic [N_REQ-1:0]        rsp_o;
   logic [N_REQ-1:0]        err_o;
   logic [LINE_W-1:0]       data_o;
   logic [N_REQ-1:0]        gnt_o;
   logic                    busy_o;

   // Memory side
   logic                    mem_req_o;
   logic [ADDR_W-1:0]       mem_addr_o;
   logic                    mem_rsp_i;
   logic [LINE_W-1:0]       mem_data_i;

   modport slave (
      input  req_i, addr_i, mem_rsp_i, mem_data_i,
      output rsp_o, err_o, data_o, gnt_o, busy_o, mem_req_o, mem_addr_o
   );

   modport master (
      output req_i, addr_i, mem_rsp_i, mem_data_i,
      input  rsp_o, err_o, data_o, gnt_o, busy_o, mem_req_o, mem_addr_o
   );

endinterface
`default_nettype wire

// File: rtl/srv_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : srv_rr_arb                                                    |
// | Purpose  : Combinational rotating-priority picker. The search starts at  |
// |            the requester after i_ptr (the previous winner) and wraps.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module srv_rr_arb #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic [N_REQ-1:0]         o_gnt
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // Walk the requesters from i_ptr+1 upwards (modulo N_REQ); first active one wins
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_idx = PTR_W'((int'(i_ptr) + i) % N_REQ);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/srv_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : srv_mem_arb                                                   |
// | Purpose  : Round-robin arbiter and sequencer in front of the single-port |
// |            line-fill memory. One outstanding transaction at a time, a    |
// |            one-cycle memory request pulse, response/error routed back to |
// |            the granted requester, watchdog for a silent memory.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module srv_mem_arb
   import srv_mem_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   srv_mem_arb_if.slave  bus
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [N_REQ-1:0]  r_gnt;
   logic [PTR_W-1:0]  r_ptr;
   logic [ADDR_W-1:0] r_addr;
   logic [WD_W-1:0]   r_wdog;

   logic [N_REQ-1:0]  w_pick;
   logic [PTR_W-1:0]  w_pick_idx;
   logic [ADDR_W-1:0] w_pick_addr;
   logic              w_start;
   logic              w_expire;

   srv_rr_arb #(
      .N_REQ (N_REQ)
   ) u_rr (
      .i_req (bus.req_i),
      .i_ptr (r_ptr),
      .o_gnt (w_pick)
   );

   // Convert the one-hot pick into an index and select that requester's address
   always_comb begin
      w_pick_idx  = '0;
      w_pick_addr = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_pick[k]) begin
            w_pick_idx  = PTR_W'(k);
            w_pick_addr = bus.addr_i[k*ADDR_W +: ADDR_W];
         end
      end
   end

   assign w_start  = (r_state == ST_IDLE) && (|bus.req_i);
   assign w_expire = (r_wdog == WD_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-cycle pulses; the response beats an expiring watchdog
   always_comb begin
      w_state_nxt   = r_state;
      bus.mem_req_o = 1'b0;
      bus.rsp_o     = '0;
      bus.err_o     = '0;
      bus.data_o    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus.mem_req_o = 1'b1;
            w_state_nxt   = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_rsp_i) begin
               bus.rsp_o   = r_gnt;
               bus.data_o  = bus.mem_data_i;
               w_state_nxt = ST_IDLE;
            end else if (w_expire) begin
               bus.err_o   = r_gnt;
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Late response is swallowed so the memory is quiet before the next issue
            if (bus.mem_rsp_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch owner, round-robin pointer and line address when leaving IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt  <= '0;
         r_ptr  <= PTR_INIT;
         r_addr <= '0;
      end else if (w_start) begin
         r_gnt  <= w_pick;
         r_ptr  <= w_pick_idx;
         r_addr <= line_align(w_pick_addr);
      end
   end

   // Watchdog: cleared on issue, counts WAIT cycles, saturates instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_wdog <= '0;
      end else if ((r_state == ST_WAIT) && (r_wdog != WD_MAX)) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   assign bus.gnt_o      = (r_state == ST_IDLE) ? '0 : r_gnt;
   assign bus.busy_o     = (r_state != ST_IDLE);
   assign bus.mem_addr_o = r_addr;

endmodule
`default_nettype wire
